// File: rtl/vga_font_wr_sched.sv
// Font RAM write scheduler: queues glyph-row writes and issues them only inside display blanking.
// Optional statistics counters are built when VGA_FONTSCHED_STATS_EN is defined.
module vga_font_wr_sched #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int GUARD_CYC  = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [ADDR_WIDTH-1:0]         req_addr_i,
  input  logic [DATA_WIDTH-1:0]         req_data_i,
  input  logic                          blank_i,
  output logic                          fm_wr_en_o,
  output logic [ADDR_WIDTH-1:0]         fm_addr_w_o,
  output logic [DATA_WIDTH-1:0]         fm_din_o,
  output logic [$clog2(FIFO_DEPTH):0]   pending_o,
  output logic                          busy_o,
  output logic [1:0]                    dbg_state_o
`ifdef VGA_FONTSCHED_STATS_EN
  ,
  output logic [15:0]                   stat_wr_o,
  output logic [15:0]                   stat_stall_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [3:0] GUARD_TH = 4'(GUARD_CYC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // Handshake: a request is taken at a rising edge when req_valid_i and req_ready_o are both 1;
  // req_ready_o depends only on the registered occupancy, never on a same-cycle pop.

  logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [3:0]       r_guard;
  state_t           r_state;
  state_t           w_next_state;

  logic             w_empty;
  logic             w_full;
  logic             w_last;
  logic             w_push;
  logic             w_pop;
  logic             w_guard_ok;
  logic             w_wr_en;
  logic [ENT_W-1:0] w_head;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_last     = (r_count == CNT_W'(1));
  assign w_guard_ok = (r_guard >= GUARD_TH);
  assign w_push     = req_valid_i & ~w_full;
  assign w_pop      = w_wr_en;
  assign w_head     = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {req_addr_i, req_data_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Consecutive blanking cycles seen so far; saturates so long blanking stays guard_ok.
  always_ff @(posedge clk_i) begin
    if (rst_i || !blank_i) begin
      r_guard <= '0;
    end else if (r_guard != 4'hF) begin
      r_guard <= r_guard + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_push) w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (w_wr_en) begin
          if (w_last && !w_push) w_next_state = S_IDLE;
          else                   w_next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_wr_en && w_last && !w_push) w_next_state = S_IDLE;
        else if (!blank_i)                w_next_state = S_WAIT;
        else if (w_empty && !w_push)      w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_wr_en = blank_i & w_guard_ok & ~w_empty & (r_state != S_IDLE);
    busy_o  = (r_state != S_IDLE);
  end

  assign req_ready_o = ~w_full;
  assign fm_wr_en_o  = w_wr_en;
  assign fm_addr_w_o = w_wr_en ? w_head[ENT_W-1:DATA_WIDTH] : '0;
  assign fm_din_o    = w_wr_en ? w_head[DATA_WIDTH-1:0]     : '0;
  assign pending_o   = r_count;
  assign dbg_state_o = r_state;

`ifdef VGA_FONTSCHED_STATS_EN
  logic [15:0] r_stat_wr;
  logic [15:0] r_stat_stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stat_wr    <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_pop)                      r_stat_wr    <= r_stat_wr + 16'd1;
      if (req_valid_i && w_full)      r_stat_stall <= r_stat_stall + 16'd1;
    end
  end

  assign stat_wr_o    = r_stat_wr;
  assign stat_stall_o = r_stat_stall;
`endif

endmodule

// File: tb/tb_vga_font_wr_sched.sv
// Directed bench for vga_font_wr_sched: expected writes queued at push, checked by a negedge monitor.
module tb_vga_font_wr_sched;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [10:0] req_addr_i;
  logic [7:0]  req_data_i;
  logic        blank_i;
  logic        fm_wr_en_o;
  logic [10:0] fm_addr_w_o;
  logic [7:0]  fm_din_o;
  logic [4:0]  pending_o;
  logic        busy_o;
  logic [1:0]  dbg_state_o;
`ifdef VGA_FONTSCHED_STATS_EN
  logic [15:0] stat_wr_o;
  logic [15:0] stat_stall_o;
`endif

  logic [18:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  vga_font_wr_sched dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .blank_i     (blank_i),
    .fm_wr_en_o  (fm_wr_en_o),
    .fm_addr_w_o (fm_addr_w_o),
    .fm_din_o    (fm_din_o),
    .pending_o   (pending_o),
    .busy_o      (busy_o),
    .dbg_state_o (dbg_state_o)
`ifdef VGA_FONTSCHED_STATS_EN
    ,
    .stat_wr_o    (stat_wr_o),
    .stat_stall_o (stat_stall_o)
`endif
  );

  // clock / watchdog
  always #20 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary line");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [10:0] a, input logic [7:0] d);
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_data_i  = d;
    @(negedge clk_i);
    check("push_ready", int'(req_ready_o), 1);
    @(posedge clk_i);
    exp_q.push_back({a, d});
    #1;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_data_i  = '0;
  endtask

  task automatic sample_wr(output logic w);
    @(negedge clk_i);
    w = fm_wr_en_o;
    tick();
  endtask

  // scoreboard monitor
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (fm_wr_en_o) begin
        n_checks++;
        if (blank_i !== 1'b1) begin
          n_fail++;
          $display("FAIL wr_outside_blank: got wr_en=1 blank=%0b required blank=1", blank_i);
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got addr=%h data=%h required no write", fm_addr_w_o, fm_din_o);
        end else begin
          logic [18:0] e;
          e = exp_q.pop_front();
          if ({fm_addr_w_o, fm_din_o} !== e) begin
            n_fail++;
            $display("FAIL write_data: got addr=%h data=%h required addr=%h data=%h",
                     fm_addr_w_o, fm_din_o, e[18:8], e[7:0]);
          end
        end
      end else begin
        n_checks++;
        if (fm_addr_w_o !== '0 || fm_din_o !== '0) begin
          n_fail++;
          $display("FAIL idle_outputs: got addr=%h data=%h required 0/0", fm_addr_w_o, fm_din_o);
        end
      end
    end
  end

  initial begin
    logic w;
    int   cnt;
    int   k;

    // 1: reset with valid held high
    rst_i = 1'b1; req_valid_i = 1'b1; req_addr_i = 11'h123; req_data_i = 8'h55; blank_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_data_i = '0;
    @(negedge clk_i);
    check("rst_ready", int'(req_ready_o), 1);
    check("rst_pending", int'(pending_o), 0);
    check("rst_wr_en", int'(fm_wr_en_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_state", int'(dbg_state_o), 0);
    tick();

    // 2: three writes wait for blanking, then issue on blank cycles 3..5
    push(11'h410, 8'hFF);
    push(11'h411, 8'h81);
    push(11'h412, 8'h00);
    @(negedge clk_i);
    check("t2_pending", int'(pending_o), 3);
    check("t2_wr_en_low", int'(fm_wr_en_o), 0);
    check("t2_busy", int'(busy_o), 1);
    tick();
    blank_i = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      sample_wr(w);
      check($sformatf("t2_wr_cycle%0d", i), int'(w), (i >= 3 && i <= 5) ? 1 : 0);
    end
    check("t2_idle_busy", int'(busy_o), 0);
    check("t2_idle_pending", int'(pending_o), 0);
    blank_i = 1'b0;
    tick();

    // 3: fill to depth, hold 17th, one pop frees one slot (no full bypass)
    for (int i = 0; i < 16; i++) push(11'h100 + 11'(i), 8'(i + 8'h10));
    check("t3_full_pending", int'(pending_o), 16);
    check("t3_full_ready", int'(req_ready_o), 0);
    req_valid_i = 1'b1; req_addr_i = 11'h1FF; req_data_i = 8'h5A;
    repeat (3) tick();
    check("t3_held_pending", int'(pending_o), 16);
`ifdef VGA_FONTSCHED_STATS_EN
    check("t3_stall_3", int'(stat_stall_o), 3);
`endif
    blank_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk_i);
      check($sformatf("t3_ready_blank%0d", i), int'(req_ready_o), 0);
      check($sformatf("t3_wr_blank%0d", i), int'(fm_wr_en_o), (i == 3) ? 1 : 0);
      tick();
    end
    blank_i = 1'b0;
    @(negedge clk_i);
    check("t3_ready_after_pop", int'(req_ready_o), 1);
    @(posedge clk_i);
    exp_q.push_back({11'h1FF, 8'h5A});
    #1;
    req_valid_i = 1'b0; req_addr_i = '0; req_data_i = '0;
    check("t3_pending_refill", int'(pending_o), 16);
`ifdef VGA_FONTSCHED_STATS_EN
    check("t3_stall_6", int'(stat_stall_o), 6);
`endif
    blank_i = 1'b1;
    for (k = 0; k < 60 && busy_o; k++) tick();
    check("t3_drain_timeout", (k < 60) ? 1 : 0, 1);
    check("t3_drain_pending", int'(pending_o), 0);
    blank_i = 1'b0;
    tick();

    // 4: blanking window too short for all four, remainder in the next window
    for (int i = 0; i < 4; i++) push(11'h7F0 + 11'(i), 8'hA5 + 8'(i));
    blank_i = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      sample_wr(w);
      cnt += int'(w);
    end
    check("t4_first_window", cnt, 2);
    blank_i = 1'b0;
    tick();
    check("t4_state_wait", int'(dbg_state_o), 1);
    check("t4_pending", int'(pending_o), 2);
    blank_i = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      sample_wr(w);
      cnt += int'(w);
    end
    check("t4_second_window", cnt, 2);
    check("t4_busy", int'(busy_o), 0);
    blank_i = 1'b0;
    tick();

    // 5: long blanking, empty FIFO: push in cycle c writes only in c+1
    blank_i = 1'b1;
    repeat (4) tick();
    push(11'h055, 8'h3C);
    @(negedge clk_i);
    check("t5_wr_c1", int'(fm_wr_en_o), 1);
    tick();
    @(negedge clk_i);
    check("t5_wr_c2", int'(fm_wr_en_o), 0);
    check("t5_busy", int'(busy_o), 0);
`ifdef VGA_FONTSCHED_STATS_EN
    check("t5_stat_wr", int'(stat_wr_o), 25);
`endif
    tick();
    blank_i = 1'b0;
    tick();

    // 6: reset during WRITE discards queued entries
    for (int i = 0; i < 6; i++) push(11'h300 + 11'(i), 8'h30 + 8'(i));
    blank_i = 1'b1;
    repeat (3) tick();
    check("t6_pending_5", int'(pending_o), 5);
    check("t6_state_write", int'(dbg_state_o), 2);
    rst_i = 1'b1;
    exp_q.delete();
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("t6_wr_en", int'(fm_wr_en_o), 0);
    check("t6_pending", int'(pending_o), 0);
    check("t6_busy", int'(busy_o), 0);
`ifdef VGA_FONTSCHED_STATS_EN
    check("t6_stat_wr", int'(stat_wr_o), 0);
    check("t6_stat_stall", int'(stat_stall_o), 0);
`endif
    tick();
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      sample_wr(w);
      cnt += int'(w);
    end
    check("t6_no_writes", cnt, 0);
    blank_i = 1'b0;
    tick();

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
